// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - two-way set-associative write-back, write-allocate data cache
// Optional hit/miss statistics are compiled in with `define DCACHE_STATS_EN.
module dcache_assoc #(
    parameter int ADDR_W     = 8,
    parameter int SETS       = 4,
    parameter int LINE_BYTES = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   read,
    input  logic                                   write,
    input  logic [ADDR_W-1:0]                      address,
    input  logic [7:0]                             writedata,
    output logic [7:0]                             readdata,
    output logic                                   busywait,
    output logic                                   mem_read,
    output logic                                   mem_write,
    output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]   mem_address,
    output logic [8*LINE_BYTES-1:0]                mem_writedata,
    input  logic [8*LINE_BYTES-1:0]                mem_readdata,
    input  logic                                   mem_busywait,
    output logic [15:0]                            hit_count,
    output logic [15:0]                            miss_count
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t                 state_q, state_d;
    logic                   victim_q, victim_d;
    logic                   first_q, first_d;
    logic [SETS-1:0][1:0]   valid_q, valid_d;
    logic [SETS-1:0][1:0]   dirty_q, dirty_d;
    logic [SETS-1:0]        lru_q, lru_d;

    logic [LINE_W-1:0]      data_q [SETS][2];
    logic [TAG_W-1:0]       tag_q  [SETS][2];

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [OFF_W-1:0]       req_off;
    logic                   req, wr_req, rd_req;
    logic                   hit0, hit1, hit, hit_way;
    logic [LINE_W-1:0]      hit_line;

    logic                   line_we, line_way, tag_we;
    logic [LINE_W-1:0]      line_d;
    logic                   hit_done, miss_start;

    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign req_idx = address[OFF_W +: IDX_W];
    assign req_off = address[OFF_W-1:0];
    assign req     = read | write;
    assign wr_req  = write;
    assign rd_req  = read & ~write;

    always_comb begin
        hit0     = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
        hit1     = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
        hit      = hit0 | hit1;
        hit_way  = hit1;
        hit_line = data_q[req_idx][hit_way];
    end

    assign busywait = req & ~((state_q == IDLE) & hit);
    assign readdata = ((state_q == IDLE) && rd_req && hit) ?
                      hit_line[{req_off, 3'b000} +: 8] : 8'h00;

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        first_d       = 1'b0;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        lru_d         = lru_q;
        line_we       = 1'b0;
        line_way      = victim_q;
        line_d        = mem_readdata;
        tag_we        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        hit_done      = 1'b0;
        miss_start    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        hit_done             = 1'b1;
                        lru_d[req_idx]       = ~hit_way;
                        if (wr_req) begin
                            line_we                            = 1'b1;
                            line_way                           = hit_way;
                            line_d                             = hit_line;
                            line_d[{req_off, 3'b000} +: 8]     = writedata;
                            dirty_d[req_idx][hit_way]          = 1'b1;
                        end
                    end else begin
                        miss_start = 1'b1;
                        first_d    = 1'b1;
                        // Empty ways are filled before anything is evicted.
                        if (!valid_q[req_idx][0]) begin
                            victim_d = 1'b0;
                        end else if (!valid_q[req_idx][1]) begin
                            victim_d = 1'b1;
                        end else begin
                            victim_d = lru_q[req_idx];
                        end
                        if (valid_q[req_idx][victim_d] && dirty_q[req_idx][victim_d]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[req_idx][victim_q], req_idx};
                mem_writedata = data_q[req_idx][victim_q];
                if (!first_q && !mem_busywait) begin
                    state_d = FETCH;
                    first_d = 1'b1;
                end
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = address[ADDR_W-1:OFF_W];
                if (!first_q && !mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                line_we                    = 1'b1;
                line_way                   = victim_q;
                line_d                     = mem_readdata;
                tag_we                     = 1'b1;
                valid_d[req_idx][victim_q] = 1'b1;
                dirty_d[req_idx][victim_q] = 1'b0;
                state_d                    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            first_q  <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            first_q  <= first_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            lru_q    <= lru_d;
        end
    end

    // Line storage carries no reset; the valid bits gate its use.
    always_ff @(posedge clock) begin
        if (line_we) begin
            data_q[req_idx][line_way] <= line_d;
        end
        if (tag_we) begin
            tag_q[req_idx][victim_q] <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic        after_update_q, after_update_d;

    always_comb begin
        after_update_d = (state_q == UPDATE);
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        // The hit that retires a refilled request was already counted as a miss.
        if (hit_done && !after_update_q && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss_start && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count_q    <= '0;
            miss_count_q   <= '0;
            after_update_q <= 1'b0;
        end else begin
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            after_update_q <= after_update_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_stats;
    assign unused_stats = hit_done ^ miss_start;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - table-driven scoreboard bench for dcache_assoc
module tb_dcache_assoc;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    dcache_assoc dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       miss;
        logic       wb;
        logic [5:0] wb_addr;
        int         lat;
    } vec_t;

    int          checks;
    int          failures;
    int          exp_hits;
    int          exp_misses;
    int          lat;
    int          wait_cnt;
    logic [1:0]  last_kind;
    logic        mem_init;
    logic [31:0] mem [64];
    logic [7:0]  ref_mem [256];
    logic [7:0]  exp_q [$];
    vec_t        vecs [16];

    function automatic logic [31:0] init_line(input int a);
        logic [31:0] l;
        if (a == 9) return 32'hDDCCBBAA;
        for (int i = 0; i < 4; i++) l[i*8 +: 8] = 8'((a*4 + i) * 37 + 5);
        return l;
    endfunction

    // Memory model: busy for `lat` cycles of each request phase, writes land on the edge.
    assign mem_busywait = (mem_read | mem_write) &&
        ((({mem_read, mem_write} == last_kind) ? wait_cnt : 0) < lat);

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_line(i);
            wait_cnt  <= 0;
            last_kind <= 2'b00;
        end else begin
            if (mem_read) mem_readdata <= mem[mem_address];
            if (mem_write) mem[mem_address] <= mem_writedata;
            wait_cnt  <= ((({mem_read, mem_write} == last_kind) ? wait_cnt : 0)) + 1;
            last_kind <= {mem_read, mem_write};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [7:0] d,
                                input logic m, input logic w, input logic [5:0] wa, input int l);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.miss = m; v.wb = w; v.wb_addr = wa; v.lat = l;
        return v;
    endfunction

    function automatic int phase_cycles(input int l);
        return (l + 1 > 2) ? l + 1 : 2;
    endfunction

    task automatic resync_ref();
        for (int a = 0; a < 64; a++)
            for (int i = 0; i < 4; i++) ref_mem[a*4 + i] = mem[a][i*8 +: 8];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        resync_ref();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Drives one request (called #1 after a rising edge) and scores everything it produced.
    task automatic do_access(input vec_t v, input string tag);
        int          stall;
        logic        done, seen_fetch, seen_wb, order_ok, quiet_ok;
        logic [5:0]  f_addr, wb_addr;
        logic [31:0] wb_data, wb_exp;
        logic [7:0]  rd;
        int          exp_stall;
        stall = 0; done = 0; seen_fetch = 0; seen_wb = 0; order_ok = 1; quiet_ok = 1;
        f_addr = '0; wb_addr = '0; wb_data = '0; rd = '0;
        for (int i = 0; i < 4; i++) wb_exp[i*8 +: 8] = ref_mem[{v.wb_addr, i[1:0]}];
        lat       = v.lat;
        address   = v.addr;
        writedata = v.wdata;
        write     = v.wr;
        read      = ~v.wr;
        if (!v.wr) exp_q.push_back(ref_mem[v.addr]);
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (!busywait) begin
                done = 1;
                rd   = readdata;
                break;
            end
            stall++;
            if (readdata !== 8'h00) quiet_ok = 0;
            if (mem_write) begin
                seen_wb = 1; wb_addr = mem_address; wb_data = mem_writedata;
                if (seen_fetch) order_ok = 0;
            end
            if (mem_read) begin
                seen_fetch = 1; f_addr = mem_address;
            end
            if (!mem_read && !mem_write && (mem_address !== 6'h0 || mem_writedata !== 32'h0))
                quiet_ok = 0;
        end
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        chk({tag, "_done"}, done, 1'b1);
        exp_stall = v.miss ? (2 + phase_cycles(v.lat) + (v.wb ? phase_cycles(v.lat) : 0)) : 0;
        chk({tag, "_stall"}, stall, exp_stall);
        chk({tag, "_fetch"}, seen_fetch, v.miss);
        chk({tag, "_wb"}, seen_wb, v.wb);
        if (v.miss) begin
            chk({tag, "_faddr"}, f_addr, v.addr[7:2]);
            chk({tag, "_quiet"}, quiet_ok, 1'b1);
        end
        if (v.wb) begin
            chk({tag, "_wbaddr"}, wb_addr, v.wb_addr);
            chk({tag, "_wbdata"}, wb_data, wb_exp);
            chk({tag, "_wborder"}, order_ok, 1'b1);
        end
        if (!v.wr) begin
            if (exp_q.size() == 0) chk({tag, "_sbempty"}, 1'b0, 1'b1);
            else chk({tag, "_rdata"}, rd, exp_q.pop_front());
        end else begin
            ref_mem[v.addr] = v.wdata;
        end
        if (v.miss) exp_misses++;
        else exp_hits++;
    endtask

    task automatic chk_stats(input string tag);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hits"}, hit_count, exp_hits);
        chk({tag, "_misses"}, miss_count, exp_misses);
`else
        chk({tag, "_hits"}, hit_count, 16'h0);
        chk({tag, "_misses"}, miss_count, 16'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        checks = 0; failures = 0; exp_hits = 0; exp_misses = 0;
        reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        lat = 0; mem_init = 1'b1;

        vecs[0]  = mk(0, 8'h24, 8'h00, 1, 0, 6'h00, 0);
        vecs[1]  = mk(1, 8'h25, 8'h5A, 0, 0, 6'h00, 0);
        vecs[2]  = mk(0, 8'h25, 8'h00, 0, 0, 6'h00, 0);
        vecs[3]  = mk(0, 8'h34, 8'h00, 1, 0, 6'h00, 2);
        vecs[4]  = mk(0, 8'h24, 8'h00, 0, 0, 6'h00, 0);
        vecs[5]  = mk(0, 8'h44, 8'h00, 1, 0, 6'h00, 0);
        vecs[6]  = mk(0, 8'h24, 8'h00, 0, 0, 6'h00, 0);
        vecs[7]  = mk(0, 8'h34, 8'h00, 1, 0, 6'h00, 0);
        vecs[8]  = mk(1, 8'h36, 8'h77, 0, 0, 6'h00, 0);
        vecs[9]  = mk(0, 8'h24, 8'h00, 0, 0, 6'h00, 0);
        vecs[10] = mk(0, 8'h54, 8'h00, 1, 1, 6'h0D, 3);
        vecs[11] = mk(0, 8'h36, 8'h00, 1, 1, 6'h09, 1);
        vecs[12] = mk(1, 8'h08, 8'h11, 1, 0, 6'h00, 0);
        vecs[13] = mk(0, 8'h08, 8'h00, 0, 0, 6'h00, 0);
        vecs[14] = mk(0, 8'hFB, 8'h00, 1, 0, 6'h00, 0);
        vecs[15] = mk(0, 8'h0B, 8'h00, 0, 0, 6'h00, 0);

        @(posedge clock);
        #1 mem_init = 1'b0;
        @(negedge clock);
        chk("rst_busywait", busywait, 1'b0);
        chk("rst_readdata", readdata, 8'h00);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, 6'h00);
        chk("rst_mem_writedata", mem_writedata, 32'h0);
        chk("rst_hit_count", hit_count, 16'h0);
        chk("rst_miss_count", miss_count, 16'h0);
        do_reset();

        // Cold read of 8'h24 must return the fetched byte 8'hAA.
        do_access(vecs[0], "v0");
        chk("cold_mem_line", mem_readdata, 32'hDDCCBBAA);
        chk_stats("cold");
        for (int i = 1; i < 16; i++) do_access(vecs[i], $sformatf("v%0d", i));
        chk_stats("table");

        // Reset in the middle of a slow fetch abandons it and invalidates the cache.
        lat = 20;
        address = 8'h24; read = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (mem_read) begin
                seen = 1;
                break;
            end
        end
        chk("rstmid_fetch_seen", seen, 1);
        read  = 1'b0;
        reset = 1'b0;
        #1;
        chk("rstmid_mem_read_drop", mem_read, 1'b0);
        chk("rstmid_mem_address", mem_address, 6'h00);
        @(posedge clock);
        #1 reset = 1'b1;
        resync_ref();
        exp_hits = 0; exp_misses = 0;
        chk_stats("rstmid");
        do_access(mk(0, 8'h24, 8'h00, 1, 0, 6'h00, 0), "rstmid_reread");

        // Three misses then five hits for the statistics counters.
        do_reset();
        do_access(mk(0, 8'h24, 8'h00, 1, 0, 6'h00, 0), "st0");
        do_access(mk(0, 8'h34, 8'h00, 1, 0, 6'h00, 0), "st1");
        do_access(mk(0, 8'h08, 8'h00, 1, 0, 6'h00, 0), "st2");
        do_access(mk(0, 8'h25, 8'h00, 0, 0, 6'h00, 0), "st3");
        do_access(mk(0, 8'h24, 8'h00, 0, 0, 6'h00, 0), "st4");
        do_access(mk(0, 8'h35, 8'h00, 0, 0, 6'h00, 0), "st5");
        do_access(mk(0, 8'h09, 8'h00, 0, 0, 6'h00, 0), "st6");
        do_access(mk(0, 8'h26, 8'h00, 0, 0, 6'h00, 0), "st7");
        chk_stats("stats");
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Two-way set-associative, write-back, write-allocate data cache sitting between the CPU load/store path and the block-oriented data memory. It is the parametrised successor of the team's direct-mapped data cache, with configurable address width, set count and line size. It adds per-set LRU replacement, invalid-way-first allocation and an optional hit/miss statistics unit. It stalls the CPU through `busywait` on misses and moves whole lines to and from memory.

## Interface
- ADDR_W, 8: CPU byte-address width.
- SETS, 4: number of sets; a power of two, at least 2.
- LINE_BYTES, 4: bytes per line; a power of two, at least 4. OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- read  in  1  CPU load request; held until `busywait` is low at a rising edge.
- write  in  1  CPU store request; same hold rule as `read`.
- address  in  ADDR_W  byte address, split as {tag, index, offset}.
- writedata  in  8  store byte.
- readdata  out  8  load byte; combinational.
- busywait  out  1  CPU stall.
- mem_read  out  1  line fetch request.
- mem_write  out  1  line write-back request.
- mem_address  out  ADDR_W-OFF_W  line address.
- mem_writedata  out  8*LINE_BYTES  victim line; byte 0 is in bits [7:0].
- mem_readdata  in  8*LINE_BYTES  fetched line.
- mem_busywait  in  1  memory busy.
- hit_count  out  16  read/write hits; valid only when statistics are compiled in.
- miss_count  out  16  read/write misses; valid only when statistics are compiled in.

## Operation
- Storage per set: 2 ways, each holding data, tag, valid and dirty; 1 LRU bit per set. LRU = way that is least recently used.
- Hit: the way is valid and its tag equals address[ADDR_W-1 -: TAG_W]. Hitting both ways is impossible by construction.
- If `read` and `write` are both high, the request is treated as a write.
- FSM states are IDLE, WRITEBACK, FETCH and UPDATE.
- IDLE, hit, read:
  - `readdata` = the addressed byte of the hit way.
  - `busywait` = 0.
  - On the edge, LRU is set to the other way.
- IDLE, hit, write:
  - On the edge the byte is written and the way's dirty bit is set.
  - LRU is set to the other way.
- IDLE, miss:
  - Victim selection, in priority order: invalid way 0, then invalid way 1, then the LRU way.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FETCH.
  - The victim choice is registered and is held until UPDATE.
- WRITEBACK:
  - mem_write = 1, mem_address = {victim tag, index}, mem_writedata = victim line.
  - Go to FETCH.
- FETCH:
  - mem_read = 1, mem_address = address[ADDR_W-1:OFF_W].
  - Go to UPDATE.
- UPDATE:
  - Write mem_readdata, the tag and valid=1 into the victim way; clear its dirty bit.
  - Return to IDLE. The request then completes as a hit, and that hit updates LRU.
- `busywait` = (read|write) & ~(state==IDLE & hit).
- `readdata` = 0 unless read & hit in IDLE.
- In IDLE, UPDATE, and FETCH/WRITEBACK when not requesting: mem_read = mem_write = 0, mem_address = 0, mem_writedata = 0.

## Timing
- Reset values of outputs:
  - busywait: combinational, so 0 with no request.
  - readdata = 0, mem_read = 0, mem_write = 0, mem_address = 0, mem_writedata = 0.
  - hit_count = 0, miss_count = 0.
- Reset also clears all valid bits, dirty bits and LRU bits, and sets state = IDLE.
- Data and tag arrays are not reset.
- Hit latency: 0 stall cycles; the request completes at the first edge.
- Memory handshake, WRITEBACK and FETCH: the FSM leaves the state at a rising edge where mem_busywait = 0, excluding the first edge spent in the state. The request is held stable throughout.
- Miss latency:
  - Clean miss: FETCH cycles + 1 UPDATE cycle + 1 IDLE hit cycle.
  - Dirty miss: additionally the WRITEBACK cycles.
- Reset asserted mid-miss:
  - mem_read/mem_write drop immediately (asynchronously).
  - The FSM goes to IDLE and the cache is invalidated.
  - The memory transaction is abandoned.
- `address`/`read`/`write` changing while `busywait` = 1 is a CPU protocol violation; behaviour is undefined.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_count increments on each completed IDLE hit, excluding the completing hit after a miss's UPDATE.
  - miss_count increments on each IDLE->WRITEBACK/FETCH transition.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Not defined: the counter logic is absent and both ports are tied to 0.

## Test plan
- Cold read of 8'h24 after reset:
  - Sequence is FETCH, then UPDATE with mem_address = 6'h09 and mem_readdata = 32'hDDCCBBAA.
  - Then readdata = 8'hAA with busywait low.
  - Stats: miss_count = 1, hit_count = 0.
- Write 8'h5A to 8'h25, then read 8'h25 → readdata = 8'h5A. No memory traffic after the initial fill.
- Fill set 1 with tags 2 and 3; read tag 2 (way 0 becomes MRU); read 8'h44 (tag 4) → way 1 (tag 3) is evicted. Way 0 then still hits on 8'h24.
- Dirty eviction: write to tag 3 in set 1, then access a new tag that evicts it.
  - WRITEBACK first, with mem_address = {4'h3, 2'h1} and the modified line.
  - Then FETCH.
- Assert reset during FETCH with mem_busywait high → mem_read = 0 immediately; the next read of the same address misses again.
- With DCACHE_STATS_EN: 3 misses followed by 5 hits → miss_count = 3, hit_count = 5.
